// File: rtl/matrix_pkg.sv
// Shared types and constants for the 5x5 8-bit matrix ULA sequencer.
package matrix_pkg;

    localparam int ROW_W = 40;
    localparam int MAT_W = 200;
    localparam int ROWS  = 5;

    localparam logic [3:0] OP_SOMA = 4'd1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_RD,
        EXEC,
        STORE,
        RESP
    } state_t;

    // Opcode and scalar travel together from command capture to the ULA.
    typedef struct packed {
        logic [3:0] opcode;
        logic [7:0] escalar;
    } ula_cmd_t;

    // Load index 0..4 selects an A row, 5..9 selects a B row; fold to 0..4.
    function automatic logic [2:0] row_sel(input logic [3:0] idx);
        logic [3:0] r;
        r = (idx < 4'(ROWS)) ? idx : idx - 4'(ROWS);
        return r[2:0];
    endfunction

endpackage

// File: rtl/matrix_row_packer.sv
// Five-row capture register; one row written per cycle by index.
module matrix_row_packer
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [2:0]       row_idx,
    input  logic [ROW_W-1:0] row_data,
    output logic [MAT_W-1:0] mat
);

    logic [ROWS-1:0][ROW_W-1:0] rows_q;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        // Each row loads only when its index is selected.
        always_ff @(posedge clk) begin
            if (rst)
                rows_q[r] <= '0;
            else if (wr_en && row_idx == 3'(r))
                rows_q[r] <= row_data;
        end
    end

    assign mat = rows_q;

endmodule

// File: rtl/matrix_op_sequencer.sv
// Fetches A and B from the row RAM, drives the ULA handshake, writes the
// result back row by row. One operation in flight.
module matrix_op_sequencer
    import matrix_pkg::*;
#(
    parameter int AW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [7:0]       cmd_escalar,
    input  logic [AW-1:0]    cmd_addr_a,
    input  logic [AW-1:0]    cmd_addr_b,
    input  logic [AW-1:0]    cmd_addr_r,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_rd_en,
    input  logic [ROW_W-1:0] mem_rdata,
    output logic             mem_wr_en,
    output logic [ROW_W-1:0] mem_wdata,
    output logic             ula_start,
    output logic [3:0]       ula_opcode,
    output logic [7:0]       ula_escalar,
    output logic [MAT_W-1:0] ula_matriz_a,
    output logic [MAT_W-1:0] ula_matriz_b,
    input  logic [MAT_W-1:0] ula_result,
    input  logic             ula_done,
    output logic             busy,
    output logic             done_pulse,
    output logic             err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [3:0] LOAD_LAST  = 4'(2 * ROWS - 1);
    localparam logic [3:0] STORE_LAST = 4'(ROWS - 1);

    state_t                     state_q, state_d;
    logic [3:0]                 cnt_q;
    logic [TW-1:0]              tcnt_q;
    ula_cmd_t                   cmd_q;
    logic [AW-1:0]              addr_a_q, addr_b_q, addr_r_q;
    logic [ROWS-1:0][ROW_W-1:0] res_q;
    logic                       err_q;
    logic                       ready_q;
    logic                       rd_vld_q;
    logic [3:0]                 rd_idx_q;
    logic                       accept;
    logic                       tmo_hit;

    assign accept  = cmd_valid && ready_q;
    assign tmo_hit = (tcnt_q == TW'(TIMEOUT - 1));

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = LOAD;
            LOAD:    if (cnt_q == LOAD_LAST) state_d = WAIT_RD;
            WAIT_RD: if (!ula_done) state_d = EXEC;
            EXEC: begin
                if (ula_done)     state_d = STORE;
                else if (tmo_hit) state_d = RESP;
            end
            STORE:   if (cnt_q == STORE_LAST) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state register only, so strobes are glitch-free.
    always_comb begin
        mem_rd_en  = (state_q == LOAD);
        mem_wr_en  = (state_q == STORE);
        ula_start  = (state_q == EXEC);
        busy       = (state_q != IDLE);
        done_pulse = (state_q == RESP);
        mem_addr   = '0;
        mem_wdata  = '0;
        if (state_q == LOAD) begin
            if (cnt_q < 4'(ROWS))
                mem_addr = addr_a_q + AW'(cnt_q);
            else
                mem_addr = addr_b_q + AW'(cnt_q - 4'(ROWS));
        end else if (state_q == STORE) begin
            mem_addr  = addr_r_q + AW'(cnt_q);
            mem_wdata = res_q[cnt_q[2:0]];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Ready is registered so it stays low through reset and rises one cycle later.
    always_ff @(posedge clk) begin
        if (rst) ready_q <= 1'b0;
        else     ready_q <= (state_d == IDLE);
    end

    // Row counter for LOAD (0..9) and STORE (0..4); restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if ((state_q == LOAD || state_q == STORE) && state_d == state_q)
            cnt_q <= cnt_q + 4'd1;
        else
            cnt_q <= '0;
    end

    // Cycles spent waiting in EXEC.
    always_ff @(posedge clk) begin
        if (rst)                 tcnt_q <= '0;
        else if (state_q == EXEC) tcnt_q <= tcnt_q + TW'(1);
        else                     tcnt_q <= '0;
    end

    // Command capture on handshake; held until the next command.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q    <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_r_q <= '0;
        end else if (accept) begin
            cmd_q    <= '{opcode: cmd_opcode, escalar: cmd_escalar};
            addr_a_q <= cmd_addr_a;
            addr_b_q <= cmd_addr_b;
            addr_r_q <= cmd_addr_r;
        end
    end

    // Read-data valid one cycle after the strobe, with the row index it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
            rd_idx_q <= '0;
        end else begin
            rd_vld_q <= mem_rd_en;
            rd_idx_q <= cnt_q;
        end
    end

    // Result latched on the done handshake.
    always_ff @(posedge clk) begin
        if (rst)
            res_q <= '0;
        else if (state_q == EXEC && ula_done)
            res_q <= ula_result;
    end

    // Sticky timeout flag, cleared by the next accepted command.
    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (accept)
            err_q <= 1'b0;
        else if (state_q == EXEC && !ula_done && tmo_hit)
            err_q <= 1'b1;
    end

    matrix_row_packer u_pack_a (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (rd_vld_q && rd_idx_q < 4'(ROWS)),
        .row_idx  (row_sel(rd_idx_q)),
        .row_data (mem_rdata),
        .mat      (ula_matriz_a)
    );

    matrix_row_packer u_pack_b (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (rd_vld_q && rd_idx_q >= 4'(ROWS)),
        .row_idx  (row_sel(rd_idx_q)),
        .row_data (mem_rdata),
        .mat      (ula_matriz_b)
    );

    assign ula_opcode  = cmd_q.opcode;
    assign ula_escalar = cmd_q.escalar;
    assign cmd_ready   = ready_q;
    assign err         = err_q;

endmodule

// File: doc/matrix_op_sequencer.md
Name: matrix_op_sequencer

Overview:
- Sequencer for the 5x5 8-bit matrix ULA.
- Accepts one command: opcode, scalar, and row addresses of operand A, operand B and the result.
- Fetches both operand matrices row by row from a 40-bit-wide synchronous RAM, runs the ULA start/done handshake, then writes the 200-bit result back row by row.
- Sits between the host command interface and the ULA/matrix RAM; one operation in flight at a time.

Parameters:
AW, 8, matrix RAM address width (one address = one 40-bit row)
TIMEOUT, 64, max cycles in EXEC waiting for ula_done before abort

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer idle, command accepted when cmd_valid&cmd_ready
cmd_opcode  in  4  ULA opcode
cmd_escalar  in  8  scalar operand
cmd_addr_a / cmd_addr_b / cmd_addr_r  in  AW each  base row address of A, B, result
mem_addr  out  AW  RAM address
mem_rd_en  out  1  RAM read strobe; data valid on mem_rdata next cycle
mem_rdata  in  40  RAM read data
mem_wr_en  out  1  RAM write strobe
mem_wdata  out  40  RAM write data
ula_start  out  1  ULA start, held until ula_done
ula_opcode  out  4  latched opcode
ula_escalar  out  8  latched scalar
ula_matriz_a / ula_matriz_b  out  200  assembled operands
ula_result  in  200  ULA result
ula_done  in  1  ULA done
busy  out  1  high in every non-IDLE state
done_pulse  out  1  one-cycle completion strobe
err  out  1  sticky timeout flag; cleared on next accepted command

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset:
  - All outputs are 0, state is IDLE, and counters and operand/result registers are cleared.
  - rst mid-operation aborts immediately; a partially written result is left as is.
  - cmd_ready is 0 while rst is high and rises the cycle after release.
- Row packing: row r (0..4) occupies bits [40r +: 40] of each 200-bit matrix. Row r lives at base+r, with addition mod 2^AW (wrap permitted).
- Command capture: on handshake (edge 0), opcode, scalar and the three addresses are latched. Inputs are ignored while busy.
- State machine and timing (cycle n = after edge n; 1-cycle ULA):
  - IDLE: cmd_ready=1. Handshake moves to LOAD; err is cleared.
  - LOAD, cycles 1-10:
    - mem_rd_en=1 every cycle.
    - Addresses are addr_a+0..4, then addr_b+0..4.
    - Data of the read issued in cycle n is captured at edge n+1 into the row selected by a delayed 4-bit counter.
  - WAIT_RD, cycle 11: captures B row 4.
  - EXEC, from cycle 12:
    - ula_start=1, decoded from the state register (glitch-free).
    - When ula_done=1 (cycle 13), ula_result is latched and the state moves to STORE.
    - ula_start is 0 from cycle 14.
  - STORE, cycles 14-18: mem_wr_en=1, mem_addr=addr_r+r, mem_wdata = result row r.
  - RESP, cycle 19: done_pulse=1, then IDLE. cmd_ready=1 at cycle 20.
- ULA handshake rules:
  - ula_start is never asserted outside EXEC.
  - EXEC is entered only when ula_done=0. If ula_done is still high, remain in WAIT_RD.
- Timeout: if a TIMEOUT-cycle counter in EXEC expires without ula_done:
  - err is set and no write occurs.
  - done_pulse is still issued (RESP), and the sequencer returns to IDLE.
- ula_opcode/ula_escalar/ula_matriz_a/ula_matriz_b hold their values from capture until the next command.
- mem_rd_en and mem_wr_en are never high in the same cycle.

Decomposition:
- Package matrix_pkg holds:
  - ROW_W=40, MAT_W=200, ROWS=5
  - the state enum (IDLE, LOAD, WAIT_RD, EXEC, STORE, RESP)
  - opcode constants (OP_SOMA=1)
- Sub-module matrix_row_packer: 5-row capture register with row-index write enable, reused for A and B. Everything else stays in the top.

Test Plan:
- Reset mid-run: assert rst during LOAD (cycle 5) -> next cycle all outputs 0, cmd_ready=1 after release, no mem_wr_en ever.
- Sum: A rows=0x0101010101 at 0x10-0x14, B rows=0x0202020202 at 0x20-0x24, opcode 1, addr_r=0x30 -> RAM 0x30-0x34 all 0x0303030303; done_pulse exactly at cycle 19; err=0.
- Byte overflow: A=0xFF in every element, B=0x01 -> result 0x00 per element (no carry between bytes).
- Address wrap: addr_a=0xFE, AW=8 -> reads 0xFE, 0xFF, 0x00, 0x01, 0x02.
- Timeout: ULA model holds ula_done=0 -> err=1 after 64 EXEC cycles, no writes, done_pulse once; next command clears err.
- Back-to-back: cmd_valid held high with two commands -> second accepted at cycle 20; ula_start low for at least 6 cycles between operations.
